// File: rtl/mult_controller_if.sv
// mult_controller_if
//   Groups the controller's request/status signals and the handshake with the
//   shift-add datapath into one bundle.
//   master : environment side (top level + datapath). It drives start, abort,
//            zflag and lsb_multiplicand, and observes the controls and status.
//   slave  : the controller itself.
//   Signals:
//     start, abort             request / cancel from the top level
//     zflag, lsb_multiplicand  datapath status (multiplicand == 0, multiplicand bit 0)
//     load, psel, reg_en,      datapath controls
//     shift_en
//     busy, done, result_valid status back to the top level
//     overrun, iter_count
interface mult_controller_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic             zflag;
    logic             lsb_multiplicand;
    logic             load;
    logic             psel;
    logic             reg_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic             overrun;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start, abort, zflag, lsb_multiplicand,
        input  load, psel, reg_en, shift_en,
        input  busy, done, result_valid, overrun, iter_count
    );

    modport slave (
        input  start, abort, zflag, lsb_multiplicand,
        output load, psel, reg_en, shift_en,
        output busy, done, result_valid, overrun, iter_count
    );
endinterface

// File: rtl/mult_controller.sv
// mult_controller
//   Sequencing FSM for the sequential shift-add multiplier. A rising edge on
//   start runs one product: load the operands, then alternate TEST with an
//   optional ADD and a SHIFT until the multiplicand register reaches zero or
//   MAX_ITER shifts have been done.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    mult_controller_if.slave (start/abort in, datapath status in,
//            datapath controls and busy/done/result_valid/overrun/iter_count out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a start rising edge
//   LOAD  | capture operands, clear product, reset count and flags
//   TEST  | look at zflag / lsb from the previous update and branch
//   ADD   | accumulate multiplier into the product
//   SHIFT | shift operand registers, count the iteration
//   DONE  | one-cycle completion pulse, result becomes valid
module mult_controller #(
    parameter int MAX_ITER = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_controller_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MAX_ITER);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             start_q;
    logic [CNT_W-1:0] iter_q;
    logic             overrun_q;
    logic             result_valid_q;

    logic start_edge;
    logic in_op;
    logic abort_hit;
    logic iter_limit;

    assign start_edge = bus.start & ~start_q;
    assign in_op      = (state == S_LOAD) || (state == S_TEST) ||
                        (state == S_ADD)  || (state == S_SHIFT);
    assign abort_hit  = bus.abort & in_op;
    assign iter_limit = (iter_q == ITER_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_edge) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_TEST;
            S_TEST: begin
                if (bus.zflag || iter_limit) state_nxt = S_DONE;
                else if (bus.lsb_multiplicand) state_nxt = S_ADD;
                else state_nxt = S_SHIFT;
            end
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = S_TEST;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides whatever the sequence wanted to do next.
        if (abort_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            start_q        <= 1'b0;
            iter_q         <= '0;
            overrun_q      <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Edge register runs in every state so a held start never retriggers.
            start_q <= bus.start;
            case (state)
                S_LOAD: begin
                    iter_q         <= '0;
                    overrun_q      <= 1'b0;
                    result_valid_q <= 1'b0;
                end
                S_TEST: begin
                    // Overrun only when the count limit, not zflag, ends the run.
                    if (!abort_hit && !bus.zflag && iter_limit) overrun_q <= 1'b1;
                end
                S_SHIFT: begin
                    // SHIFT is only reachable below the limit, so this cannot wrap.
                    iter_q <= iter_q + 1'b1;
                end
                S_DONE: begin
                    result_valid_q <= 1'b1;
                end
                default: ;
            endcase
            if (abort_hit) result_valid_q <= 1'b0;
        end
    end

    // Moore decode only: nothing here depends on the inputs.
    assign bus.load         = (state == S_LOAD);
    assign bus.psel         = (state == S_ADD);
    assign bus.reg_en       = (state == S_LOAD) || (state == S_ADD);
    assign bus.shift_en     = (state == S_SHIFT);
    assign bus.busy         = in_op;
    assign bus.done         = (state == S_DONE);
    assign bus.result_valid = result_valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_mult_controller.sv
// tb_mult_controller
//   Self-checking bench for mult_controller. A small behavioural shift-add
//   datapath closes the loop (zflag / lsb). Each accepted start pushes the
//   expected outcome (latency, iteration count, overrun, add count, signed
//   product) computed arithmetically from the operands; a negedge monitor pops
//   and compares on every done pulse.
module tb_mult_controller;

    localparam int MAX_ITER = 8;
    localparam int CNT_W    = 4;

    typedef struct {
        int start_cyc;
        int lat;
        int iter;
        int ovr;
        int prod;
        int adds;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    int   op_a = 0;
    int   op_b = 0;
    bit   stuck_z = 1'b0;
    bit   rv_pending = 1'b0;
    int   adds_cnt = 0;
    int   shifts_cnt = 0;
    exp_t sb[$];

    mult_controller_if #(.CNT_W(CNT_W)) bus ();

    mult_controller #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mag8(int v);
        int m;
        m = (v < 0) ? -v : v;
        return m[7:0];
    endfunction

    // Behavioural datapath: magnitude shift-add with a separate sign.
    logic [7:0]  dp_mc = '0;
    logic [15:0] dp_mp = '0;
    logic [15:0] dp_prod = '0;
    logic        dp_neg = 1'b0;

    always @(posedge clk) begin
        if (bus.load) begin
            dp_mc  <= mag8(op_a);
            dp_mp  <= {8'd0, mag8(op_b)};
            dp_neg <= (op_a < 0) ^ (op_b < 0);
        end
        if (bus.reg_en) dp_prod <= bus.psel ? dp_prod + dp_mp : 16'd0;
        if (bus.shift_en) begin
            dp_mc <= dp_mc >> 1;
            dp_mp <= dp_mp << 1;
        end
    end

    assign bus.zflag            = stuck_z ? 1'b0 : (dp_mc == 8'd0);
    assign bus.lsb_multiplicand = dp_mc[0];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: bit-serial multiply cost from the operand bits alone.
    function automatic exp_t model(int a, int b, bit stuck, int sc);
        exp_t e;
        int m;
        int k;
        int pc;
        m  = (a < 0) ? -a : a;
        k  = 0;
        pc = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                k = i + 1;
                pc++;
            end
        end
        if (stuck) k = MAX_ITER;
        e.start_cyc = sc;
        e.iter      = k;
        e.ovr       = stuck ? 1 : 0;
        e.adds      = pc;
        e.lat       = 2 + 2 * k + pc + 1;
        e.prod      = a * b;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   prod;
        if (rst_n) begin
            if (bus.load && bus.shift_en) chk("load_shift_exclusive", 1, 0);
            if (bus.reg_en && !bus.load && !bus.psel) chk("reg_en_state", 1, 0);
            if (bus.psel && !bus.reg_en) chk("psel_without_reg_en", 1, 0);
            if (bus.busy && bus.done) chk("busy_with_done", 1, 0);
            if (bus.load) begin
                adds_cnt   = 0;
                shifts_cnt = 0;
            end
            if (bus.reg_en && bus.psel) adds_cnt++;
            if (bus.shift_en) shifts_cnt++;
            if (rv_pending) begin
                chk("result_valid_after_done", int'(bus.result_valid), 1);
                rv_pending = 1'b0;
            end
            if (bus.done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e    = sb.pop_front();
                    prod = dp_neg ? -int'(dp_prod) : int'(dp_prod);
                    chk("latency", cyc - e.start_cyc, e.lat);
                    chk("iter_count", int'(bus.iter_count), e.iter);
                    chk("overrun", int'(bus.overrun), e.ovr);
                    chk("add_count", adds_cnt, e.adds);
                    chk("shift_count", shifts_cnt, e.iter);
                    chk("product", prod, e.prod);
                    rv_pending = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(int a, int b, bit expect_done);
        op_a      = a;
        op_b      = b;
        bus.start = 1'b1;
        if (expect_done) sb.push_back(model(a, b, stuck_z, cyc));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int d0;
        int n;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", int'(done_seen != d0), 1);
        tick();
    endtask

    function automatic int all_outs();
        return int'({bus.load, bus.psel, bus.reg_en, bus.shift_en, bus.busy,
                     bus.done, bus.result_valid, bus.overrun, bus.iter_count});
    endfunction

    initial begin
        int sc;
        int d0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #2;
        chk("reset_outputs", all_outs(), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_after_reset", int'(bus.busy), 0);

        // 5 x 3, then zero multiplicand, then full-width magnitude.
        launch(5, 3, 1'b1);
        wait_done(40);
        launch(0, -7, 1'b1);
        wait_done(40);
        launch(-128, 1, 1'b1);
        wait_done(40);
        stuck_z = 1'b1;
        launch(-128, 1, 1'b1);
        wait_done(40);
        stuck_z = 1'b0;

        for (int i = 0; i < 24; i++) begin
            launch(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b1);
            wait_done(40);
        end

        // Abort in the second ADD of 5 x 3 (cycle 8 after the start edge).
        d0 = done_seen;
        sc = cyc;
        launch(5, 3, 1'b0);
        repeat (7) tick();
        chk("second_add_reached", int'(bus.reg_en && bus.psel), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_result_valid", int'(bus.result_valid), 0);
        chk("abort_cycles", cyc - sc, 9);
        repeat (6) tick();
        chk("abort_no_done", done_seen, d0);
        chk("abort_stays_idle", int'(bus.busy), 0);

        // Asynchronous reset in the middle of a SHIFT.
        launch(5, 3, 1'b1);
        repeat (3) tick();
        chk("in_shift_before_reset", int'(bus.shift_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        sb.delete();
        rv_pending = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("idle_after_mid_reset", int'(bus.busy), 0);
        end
        launch(7, -9, 1'b1);
        wait_done(40);

        // Held start: one operation only.
        d0 = done_seen;
        op_a = 3;
        op_b = 11;
        bus.start = 1'b1;
        sb.push_back(model(3, 11, 1'b0, cyc));
        repeat (40) tick();
        chk("held_start_one_done", done_seen - d0, 1);
        chk("held_start_idle", int'(bus.busy), 0);
        bus.start = 1'b0;
        tick();

        // Start edge coincident with DONE is dropped.
        d0 = done_seen;
        launch(5, 3, 1'b1);
        repeat (10) tick();
        chk("in_done_cycle", int'(bus.done), 1);
        bus.start = 1'b1;
        repeat (8) tick();
        chk("done_edge_ignored_count", done_seen - d0, 1);
        chk("done_edge_ignored_idle", int'(bus.busy), 0);
        bus.start = 1'b0;
        tick();

        // Back-to-back: new edge in the cycle right after DONE.
        launch(5, 3, 1'b1);
        repeat (11) tick();
        chk("rv_before_second_op", int'(bus.result_valid), 1);
        op_a = -6;
        op_b = 10;
        bus.start = 1'b1;
        sb.push_back(model(-6, 10, 1'b0, cyc));
        tick();
        bus.start = 1'b0;
        chk("b2b_load", int'(bus.load), 1);
        tick();
        chk("b2b_rv_cleared", int'(bus.result_valid), 0);
        wait_done(40);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
